// File: rtl/cpu_run_checker_pkg.sv
// Shared types and constants for the CPU run checker: FSM states, verdict codes
// and a width helper that keeps index vectors at least one bit wide.
package cpu_run_checker_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReset,
    StRun,
    StDone
  } state_e;

  localparam logic [1:0] FailNone    = 2'd0;
  localparam logic [1:0] FailReg     = 2'd1;
  localparam logic [1:0] FailData    = 2'd2;
  localparam logic [1:0] FailTimeout = 2'd3;

  // Index width for a table of n entries, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_run_checker_if.sv
// Bundle of config, control, writeback-monitor and status signals between the
// bench-side driver (master) and the run checker (slave).
interface cpu_run_checker_if
  import cpu_run_checker_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NCHK    = 4,
  parameter int unsigned TIMEOUT = 100
);
  localparam int unsigned IdxW = idx_width(NCHK);
  localparam int unsigned CycW = $clog2(TIMEOUT + 1);

  logic              cfg_we;
  logic [IdxW-1:0]   cfg_idx;
  logic [REG_AW-1:0] cfg_reg;
  logic [XLEN-1:0]   cfg_data;
  logic              start;
  logic              wb_en;
  logic [REG_AW-1:0] wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              pass;
  logic [1:0]        fail_code;
  logic [IdxW-1:0]   fail_idx;
  logic [CycW-1:0]   cycles;

  modport master (
    output cfg_we, cfg_idx, cfg_reg, cfg_data, start, wb_en, wb_addr, wb_data,
    input  cpu_reset, busy, done, pass, fail_code, fail_idx, cycles
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_reg, cfg_data, start, wb_en, wb_addr, wb_data,
    output cpu_reset, busy, done, pass, fail_code, fail_idx, cycles
  );

endinterface

// File: rtl/cpu_run_expect_mem.sv
// Expected-writeback table: NCHK entries of {reg, value}, synchronous write,
// asynchronous read. Not reset; contents are undefined until loaded.
module cpu_run_expect_mem #(
  parameter int unsigned NCHK   = 4,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned XLEN   = 32,
  parameter int unsigned IdxW   = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IdxW-1:0]   waddr,
  input  logic [REG_AW-1:0] wreg,
  input  logic [XLEN-1:0]   wdata,
  input  logic [IdxW-1:0]   raddr,
  output logic [REG_AW-1:0] rreg,
  output logic [XLEN-1:0]   rdata
);

  logic [REG_AW+XLEN-1:0] mem_q [NCHK];

  // Table write; out-of-range indices (non-power-of-two depth) are dropped.
  always_ff @(posedge clk) begin
    if (we && ({1'b0, waddr} < (IdxW + 1)'(NCHK))) begin
      mem_q[waddr] <= {wreg, wdata};
    end
  end

  assign {rreg, rdata} = mem_q[raddr];

endmodule

// File: rtl/cpu_run_checker.sv
// Run controller / scoreboard for the single-cycle CPU bench: pulses the CPU
// reset, counts run cycles, checks each register writeback against the
// expected table in order, and latches a PASS/FAIL verdict with its cause.
module cpu_run_checker
  import cpu_run_checker_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned NCHK         = 4,
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 100
) (
  input logic              clk,
  input logic              reset,
  cpu_run_checker_if.slave bus
);

  localparam int unsigned IdxW = idx_width(NCHK);
  localparam int unsigned CycW = $clog2(TIMEOUT + 1);
  localparam int unsigned RstW = idx_width(RESET_CYCLES);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NCHK - 1);
  localparam logic [CycW-1:0] CycMax  = CycW'(TIMEOUT);
  localparam logic [RstW-1:0] RstLast = RstW'(RESET_CYCLES - 1);

  state_e            state_q;
  logic [RstW-1:0]   rcnt_q;
  logic [IdxW-1:0]   ptr_q;
  logic [CycW-1:0]   cycles_q;
  logic              cpu_reset_q, busy_q, done_q, pass_q;
  logic [1:0]        fail_code_q;
  logic [IdxW-1:0]   fail_idx_q;

  logic              mem_we;
  logic [REG_AW-1:0] exp_reg;
  logic [XLEN-1:0]   exp_data;
  logic [CycW-1:0]   cycles_nxt;
  logic              wb_hit;
  logic              verdict, v_pass, ptr_adv;
  logic [1:0]        v_code;

  // The table may only be rewritten while no run is in flight.
  assign mem_we = bus.cfg_we && ((state_q == StIdle) || (state_q == StDone));

  cpu_run_expect_mem #(
    .NCHK   (NCHK),
    .REG_AW (REG_AW),
    .XLEN   (XLEN),
    .IdxW   (IdxW)
  ) u_expect_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (bus.cfg_idx),
    .wreg  (bus.cfg_reg),
    .wdata (bus.cfg_data),
    .raddr (ptr_q),
    .rreg  (exp_reg),
    .rdata (exp_data)
  );

  assign cycles_nxt = (cycles_q == CycMax) ? cycles_q : cycles_q + 1'b1;
  assign wb_hit     = bus.wb_en && (bus.wb_addr != '0);

  // Verdict for the current RUN cycle; a writeback decision outranks timeout.
  always_comb begin
    verdict = 1'b0;
    v_pass  = 1'b0;
    v_code  = FailNone;
    ptr_adv = 1'b0;
    if (wb_hit) begin
      if (bus.wb_addr != exp_reg) begin
        verdict = 1'b1;
        v_code  = FailReg;
      end else if (bus.wb_data != exp_data) begin
        verdict = 1'b1;
        v_code  = FailData;
      end else if (ptr_q == LastIdx) begin
        verdict = 1'b1;
        v_pass  = 1'b1;
      end else begin
        ptr_adv = 1'b1;
      end
    end
    if (!verdict && (cycles_nxt == CycMax)) begin
      verdict = 1'b1;
      v_code  = FailTimeout;
    end
  end

  // Run FSM with counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      rcnt_q      <= '0;
      ptr_q       <= '0;
      cycles_q    <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_code_q <= FailNone;
      fail_idx_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            state_q     <= StReset;
            rcnt_q      <= '0;
            ptr_q       <= '0;
            cycles_q    <= '0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_code_q <= FailNone;
            fail_idx_q  <= '0;
          end
        end
        StReset: begin
          if (rcnt_q == RstLast) begin
            state_q     <= StRun;
            cpu_reset_q <= 1'b0;
          end else begin
            rcnt_q <= rcnt_q + 1'b1;
          end
        end
        StRun: begin
          cycles_q <= cycles_nxt;
          if (verdict) begin
            state_q     <= StDone;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            pass_q      <= v_pass;
            fail_code_q <= v_code;
            fail_idx_q  <= v_pass ? '0 : ptr_q;
          end else if (ptr_adv) begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.cpu_reset = cpu_reset_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_code = fail_code_q;
  assign bus.fail_idx  = fail_idx_q;
  assign bus.cycles    = cycles_q;

endmodule

// File: tb/tb_cpu_run_checker.sv
// Self-checking bench for cpu_run_checker: expected verdicts are queued when a
// run's stimulus is driven and compared when done rises.
module tb_cpu_run_checker;
  import cpu_run_checker_pkg::*;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned REG_AW       = 5;
  localparam int unsigned NCHK         = 3;
  localparam int unsigned RESET_CYCLES = 2;
  localparam int unsigned TIMEOUT      = 20;

  typedef struct {
    logic        pass;
    logic [1:0]  code;
    int unsigned idx;
    int unsigned cycles;
  } verdict_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;
  verdict_t    exp_q[$];

  cpu_run_checker_if #(
    .XLEN    (XLEN),
    .REG_AW  (REG_AW),
    .NCHK    (NCHK),
    .TIMEOUT (TIMEOUT)
  ) bus ();

  cpu_run_checker #(
    .XLEN         (XLEN),
    .REG_AW       (REG_AW),
    .NCHK         (NCHK),
    .RESET_CYCLES (RESET_CYCLES),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int unsigned idx, input int unsigned r, input int unsigned d);
    bus.cfg_we   = 1'b1;
    bus.cfg_idx  = 2'(idx);
    bus.cfg_reg  = 5'(r);
    bus.cfg_data = d;
    step();
    bus.cfg_we = 1'b0;
  endtask

  task automatic wb_write(input int unsigned r, input int unsigned d);
    bus.wb_en   = 1'b1;
    bus.wb_addr = 5'(r);
    bus.wb_data = d;
    step();
    bus.wb_en   = 1'b0;
    bus.wb_addr = '0;
    bus.wb_data = '0;
  endtask

  // Start pulse, then follow the CPU reset window into the first RUN cycle.
  task automatic start_run();
    bus.start = 1'b1;
    step();
    bus.start  = 1'b0;
    bus.cfg_we = 1'b0;
    check("start_cpu_reset0", 32'(bus.cpu_reset), 1);
    check("start_busy", 32'(bus.busy), 1);
    check("start_done_clr", 32'(bus.done), 0);
    check("start_cycles_clr", 32'(bus.cycles), 0);
    step();
    check("start_cpu_reset1", 32'(bus.cpu_reset), 1);
    step();
    check("run_cpu_reset", 32'(bus.cpu_reset), 0);
  endtask

  task automatic expect_verdict(input logic p, input logic [1:0] c, input int unsigned idx,
                                input int unsigned cyc);
    verdict_t v;
    v.pass   = p;
    v.code   = c;
    v.idx    = idx;
    v.cycles = cyc;
    exp_q.push_back(v);
  endtask

  task automatic wait_verdict();
    verdict_t e;
    int n = 0;
    while (!bus.done && n < 50) begin
      step();
      n++;
    end
    check("done_seen", 32'(bus.done), 1);
    e = exp_q.pop_front();
    check("pass", 32'(bus.pass), 32'(e.pass));
    check("fail_code", 32'(bus.fail_code), 32'(e.code));
    check("fail_idx", 32'(bus.fail_idx), e.idx);
    check("cycles", 32'(bus.cycles), e.cycles);
    check("done_cpu_reset", 32'(bus.cpu_reset), 1);
    check("done_busy", 32'(bus.busy), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cpu_reset"}, 32'(bus.cpu_reset), 1);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_pass"}, 32'(bus.pass), 0);
    check({tag, "_code"}, 32'(bus.fail_code), 0);
    check({tag, "_idx"}, 32'(bus.fail_idx), 0);
    check({tag, "_cycles"}, 32'(bus.cycles), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_reg = '0; bus.cfg_data = '0;
    bus.start = 1'b0; bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    reset = 1'b1;
    step();
    step();
    check_reset_state("por");
    reset = 1'b0;
    step();
    check_reset_state("idle");

    cfg_write(0, 1, 5);
    cfg_write(1, 2, 7);
    cfg_write(2, 3, 12);

    // In-order matching writes pass.
    start_run();
    expect_verdict(1'b1, FailNone, 0, 3);
    wb_write(1, 5);
    wb_write(2, 7);
    wb_write(3, 12);
    wait_verdict();

    // Data mismatch on second entry; verdict lands on the following edge.
    start_run();
    expect_verdict(1'b0, FailData, 1, 2);
    wb_write(1, 5);
    check("t2_done_before", 32'(bus.done), 0);
    wb_write(2, 8);
    check("t2_done_after", 32'(bus.done), 1);
    wait_verdict();

    // r0 ignored, then wrong destination register.
    start_run();
    expect_verdict(1'b0, FailReg, 1, 3);
    wb_write(0, 99);
    wb_write(1, 5);
    check("t3_r0_ignored", 32'(bus.done), 0);
    wb_write(3, 12);
    wait_verdict();

    // No writes at all: timeout.
    start_run();
    expect_verdict(1'b0, FailTimeout, 0, TIMEOUT);
    wait_verdict();

    // Reset mid-run, then restart on the retained table.
    start_run();
    wb_write(1, 5);
    repeat (4) step();
    check("t5_busy", 32'(bus.busy), 1);
    check("t5_cycles", 32'(bus.cycles), 5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_state("midrst");
    start_run();
    expect_verdict(1'b1, FailNone, 0, 3);
    wb_write(1, 5);
    wb_write(2, 7);
    wb_write(3, 12);
    wait_verdict();

    // Start/cfg while busy ignored; final match on the timeout cycle passes.
    start_run();
    expect_verdict(1'b1, FailNone, 0, TIMEOUT);
    wb_write(1, 5);
    bus.start = 1'b1;
    bus.cfg_we = 1'b1; bus.cfg_idx = 2'd2; bus.cfg_reg = 5'd3; bus.cfg_data = 99;
    step();
    bus.start = 1'b0;
    bus.cfg_we = 1'b0;
    check("t6_busy_start_cycles", 32'(bus.cycles), 2);
    check("t6_busy_start_cpu_reset", 32'(bus.cpu_reset), 0);
    wb_write(2, 7);
    repeat (16) step();
    check("t6_cycles_pre", 32'(bus.cycles), TIMEOUT - 1);
    check("t6_done_pre", 32'(bus.done), 0);
    wb_write(3, 12);
    wait_verdict();

    // Start from DONE with a same-cycle table write that must land.
    bus.cfg_we = 1'b1; bus.cfg_idx = 2'd2; bus.cfg_reg = 5'd3; bus.cfg_data = 13;
    start_run();
    expect_verdict(1'b1, FailNone, 0, 3);
    wb_write(1, 5);
    wb_write(2, 7);
    wb_write(3, 13);
    wait_verdict();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
